// File: rtl/skewed_fifo_feeder_if.sv
// Bundle between the skewed feeder and its environment: command handshake,
// per-channel FIFO heads/pops and the skewed west-edge output rows.
interface skewed_fifo_feeder_if #(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int LEN_WIDTH = 8
);
  logic                      start;
  logic [LEN_WIDTH-1:0]      len;
  logic                      busy;
  logic                      done;
  logic [NUM_CH-1:0]         empty;
  logic [NUM_CH*WIDTH-1:0]   from_fifo;
  logic [NUM_CH-1:0]         r_en;
  logic [NUM_CH*WIDTH-1:0]   to_array;
  logic [NUM_CH-1:0]         valid_out;

  modport master (
    output start, len, empty, from_fifo,
    input  busy, done, r_en, to_array, valid_out
  );

  modport slave (
    input  start, len, empty, from_fifo,
    output busy, done, r_en, to_array, valid_out
  );
endinterface

// File: rtl/skewed_fifo_feeder.sv
// Drains NUM_CH FWFT row FIFOs onto the systolic array west edge, channel c
// delayed by c cycles; a stall inserts a whole bubble row so the skew holds.
module skewed_fifo_feeder #(
  parameter int WIDTH     = 16,
  parameter int NUM_CH    = 4,
  parameter int LEN_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  skewed_fifo_feeder_if.slave bus
);
  localparam int TW = LEN_WIDTH + $clog2(NUM_CH) + 1;
  localparam int DW = NUM_CH * WIDTH;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        t_q, t_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DW-1:0]        to_array_q, to_array_d;
  logic [NUM_CH-1:0]    valid_q, valid_d;
  logic [NUM_CH-1:0]    active_s;
  logic [NUM_CH-1:0]    r_en_s;
  logic [TW-1:0]        len_ext_s;
  logic [TW-1:0]        t_last_s;
  logic                 stall_s;

  // Per-channel activity window at step t; any empty active FIFO stalls all.
  always_comb begin
    len_ext_s = TW'(len_q);
    t_last_s  = len_ext_s + TW'(NUM_CH) - TW'(2);
    for (int c = 0; c < NUM_CH; c++) begin
      active_s[c] = (t_q >= TW'(c)) && (t_q < (TW'(c) + len_ext_s));
    end
    stall_s = |(active_s & bus.empty);
  end

  // Command sequencing, pops and the next output row.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    len_d      = len_q;
    done_d     = 1'b0;
    to_array_d = {DW{1'b0}};
    valid_d    = {NUM_CH{1'b0}};
    r_en_s     = {NUM_CH{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.len != {LEN_WIDTH{1'b0}}) begin
            len_d   = bus.len;
            t_d     = {TW{1'b0}};
            state_d = ST_RUN;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!stall_s) begin
          r_en_s  = active_s;
          valid_d = active_s;
          for (int c = 0; c < NUM_CH; c++) begin
            to_array_d[c*WIDTH +: WIDTH] = active_s[c] ? bus.from_fifo[c*WIDTH +: WIDTH]
                                                       : {WIDTH{1'b0}};
          end
          if (t_q == t_last_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + TW'(1);
          end
        end else begin
          t_d = t_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
  end

  // State and output registers; rst aborts a command without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      t_q        <= {TW{1'b0}};
      len_q      <= {LEN_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      to_array_q <= {DW{1'b0}};
      valid_q    <= {NUM_CH{1'b0}};
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      to_array_q <= to_array_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.r_en      = rst ? {NUM_CH{1'b0}} : r_en_s;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.to_array  = to_array_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_skewed_fifo_feeder.sv
// Scoreboard bench: a row-level model predicts each cycle's pops and the next
// output row; a negedge monitor compares the DUT against the queued rows.
module tb_skewed_fifo_feeder;
  localparam int WIDTH     = 16;
  localparam int NUM_CH    = 4;
  localparam int LEN_WIDTH = 8;
  localparam int DW        = NUM_CH * WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  skewed_fifo_feeder_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .LEN_WIDTH(LEN_WIDTH)) bus ();

  skewed_fifo_feeder #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int                cyc;
    logic [NUM_CH-1:0] valid;
    logic [DW-1:0]     data;
    logic              done;
    logic              busy;
  } exp_t;

  exp_t              sb[$];
  logic [WIDTH-1:0]  fq[NUM_CH][$];
  int                seq[NUM_CH];
  int                n_pass = 0;
  int                n_chk  = 0;
  int                cyc    = 0;
  int                refill_pct = 0;
  logic [NUM_CH-1:0] prev_ren = '0;
  bit                m_run = 1'b0;
  int                m_row = 0;
  int                m_len = 0;
  int                last_done = -1;
  int                busy_cnt = 0;
  int                pop_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: actual %0h expected %0h", nm, cyc, act, exp);
  endtask

  // Channels that carry a word in output row r of a len-L command.
  function automatic logic [NUM_CH-1:0] row_mask(input int r, input int l);
    logic [NUM_CH-1:0] m;
    for (int c = 0; c < NUM_CH; c++) m[c] = (r >= c) && (r < c + l);
    return m;
  endfunction

  task automatic fill(input int n);
    for (int c = 0; c < NUM_CH; c++) begin
      fq[c].delete();
      for (int k = 1; k <= n; k++) fq[c].push_back(WIDTH'(c * 16 + k));
    end
  endtask

  // One clock cycle: retire last cycle's pops, drive inputs, predict outputs.
  task automatic step(input bit s, input int l, input bit r, input logic [NUM_CH-1:0] h);
    exp_t              e;
    logic [NUM_CH-1:0] emp;
    logic [NUM_CH-1:0] mask;
    logic [DW-1:0]     ff;
    @(posedge clk);
    cyc++;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (prev_ren[c] && fq[c].size() > 0) void'(fq[c].pop_front());
      if ($urandom_range(99) < refill_pct && fq[c].size() < 8) begin
        seq[c]++;
        fq[c].push_back(WIDTH'((c << 12) | (seq[c] & 12'hfff)));
      end
      emp[c] = (fq[c].size() == 0) || h[c];
      ff[c*WIDTH +: WIDTH] = (fq[c].size() > 0) ? fq[c][0] : WIDTH'($urandom);
    end
    rst           = r;
    bus.start     = s;
    bus.len       = LEN_WIDTH'(l);
    bus.empty     = emp;
    bus.from_fifo = ff;
    e.cyc = cyc; e.valid = '0; e.data = '0; e.done = 1'b0;
    prev_ren = '0;
    if (r) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (s && l != 0) begin
        m_run = 1'b1; m_row = 0; m_len = l;
      end else if (s) begin
        e.done = 1'b1;
      end
    end else begin
      mask = row_mask(m_row, m_len);
      if ((mask & emp) == '0) begin
        prev_ren = mask;
        e.valid  = mask;
        for (int c = 0; c < NUM_CH; c++)
          if (mask[c]) e.data[c*WIDTH +: WIDTH] = fq[c][0];
        m_row++;
        if (m_row == m_len + NUM_CH - 1) begin
          m_run  = 1'b0;
          e.done = 1'b1;
        end
      end
    end
    e.busy = m_run;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, '0);
  endtask

  // Directed command: optional second start, reset and one-cycle hide, then
  // done cycle (relative to start, -1 = none), busy cycles and pops checked.
  task automatic scen(input string nm, input int l1, input int l2, input int at2,
                      input int rst_at, input int hide_at, input logic [NUM_CH-1:0] hm,
                      input int fillw, input int dn, input int bz, input int pc);
    int s;
    fill(fillw);
    last_done = -1; busy_cnt = 0; pop_cnt = 0;
    step(1'b1, l1, 1'b0, '0);
    s = cyc;
    for (int i = 1; i < 24; i++)
      step(i == at2, (i == at2) ? l2 : 0, i == rst_at, (i == hide_at) ? hm : '0);
    chk({nm, "_done_cyc"}, last_done, (dn < 0) ? -1 : s + dn);
    chk({nm, "_busy_cycles"}, busy_cnt, bz);
    chk({nm, "_pops"}, pop_cnt, pc);
  endtask

  // Monitor: compares pops live and outputs against the row queued last cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("r_en", bus.r_en, prev_ren);
      if (bus.done) last_done = cyc;
      if (bus.busy) busy_cnt++;
      pop_cnt += $countones(bus.r_en);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        if (e.cyc == cyc - 1) begin
          chk("valid_out", bus.valid_out, e.valid);
          chk("to_array", bus.to_array, e.data);
          chk("done", bus.done, e.done);
          chk("busy", bus.busy, e.busy);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.len = '0; bus.empty = '1; bus.from_fifo = '0;
    for (int c = 0; c < NUM_CH; c++) seq[c] = 0;
    repeat (3) step(1'b0, 0, 1'b1, '0);
    idle(2);
    scen("basic",  3, 0, 0, 0, 0, 4'b0000, 3,  7,  6, 12);
    scen("stall",  3, 0, 0, 0, 3, 4'b0100, 3,  8,  7, 12);
    scen("len0",   0, 0, 0, 0, 0, 4'b0000, 0,  1,  0,  0);
    scen("reset",  5, 0, 0, 3, 0, 4'b0000, 5, -1,  3,  3);
    scen("ignore", 3, 9, 2, 0, 0, 4'b0000, 3,  7,  6, 12);
    scen("b2b",    3, 2, 7, 0, 0, 4'b0000, 5, 13, 11, 20);
    fill(0);
    refill_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      logic [NUM_CH-1:0] h;
      for (int c = 0; c < NUM_CH; c++) h[c] = ($urandom_range(99) < 10);
      step($urandom_range(99) < 15, $urandom_range(10, 0), $urandom_range(999) < 3, h);
    end
    refill_pct = 100;
    idle(60);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
